// File: rtl/hk628_trigger_sched.sv
`default_nettype none
// =============================================================================
// hk628_trigger_sched : debounced button requests, round-robin start/busy arbitration, low-battery preemption
// Rev 1.0 | optional HK628_SCHED_RETRIGGER_EN: re-pressing the playing button restarts it immediately
// =============================================================================

module hk628_trigger_sched #(
  parameter int NUM_BTN         = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int START_TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               low_batt_btn,
  input  logic               play_busy,
  output logic               play_start,
  output logic               play_abort,
  output logic [3:0]         play_sel,
  output logic               active,
  output logic               start_fail
);

  localparam int NIN = NUM_BTN + 1;
  localparam int PW  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW  = $clog2(START_TIMEOUT + 1);
  localparam logic [3:0] LB_SEL = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_PLAYING   = 3'd3,
    S_ABORT     = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [NIN-1:0]     sync1_q, sync2_q, samp_q, deb_q;
  logic [CW-1:0]      presc_q;
  logic               tick;
  logic [NIN-1:0]     rise;
  logic [NUM_BTN-1:0] btn_rise;
  logic               lb_rise;

  assign tick     = (presc_q == CW'(DEBOUNCE_CYCLES - 1));
  assign rise     = tick ? (sync2_q & samp_q & ~deb_q) : '0;
  assign btn_rise = rise[NUM_BTN-1:0];
  assign lb_rise  = rise[NUM_BTN];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= {low_batt_btn, btn};
      sync2_q <= sync1_q;
      presc_q <= tick ? '0 : presc_q + CW'(1);
      if (tick) begin
        samp_q <= sync2_q;
        // take the new sample only where it agrees with the previous tick's sample
        deb_q  <= (sync2_q & samp_q) | (deb_q & (sync2_q | samp_q));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler state
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [NUM_BTN-1:0] pend_q, pend_d, pend_clr, retrig_mask, requeue;
  logic               lb_q, lb_d, lb_clr;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               fail_q, fail_d;
  logic               retrig_q, retrig_d;
  logic               retrig_hit, do_requeue;
  logic               pick_found;
  logic [PW-1:0]      pick_idx, scan_idx;
  logic [PW:0]        scan_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      rr_q     <= '0;
      pend_q   <= '0;
      lb_q     <= 1'b0;
      cnt_q    <= '0;
      fail_q   <= 1'b0;
      retrig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      lb_q     <= lb_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      retrig_q <= retrig_d;
    end
  end

  always_comb begin
    retrig_hit = 1'b0;
`ifdef HK628_SCHED_RETRIGGER_EN
    if (state_q == S_PLAYING && play_busy && sel_q != LB_SEL) begin
      retrig_hit = btn_rise[sel_q[PW-1:0]];
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    retrig_d   = retrig_q;
    pend_clr   = '0;
    lb_clr     = 1'b0;
    do_requeue = 1'b0;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;

    // first pending button at or above rr_q, wrapping
    for (int j = 0; j < NUM_BTN; j++) begin
      scan_sum = {1'b0, rr_q} + (PW+1)'(j);
      if (scan_sum >= (PW+1)'(NUM_BTN)) begin
        scan_sum = scan_sum - (PW+1)'(NUM_BTN);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!pick_found && pend_q[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (lb_q) begin
          lb_clr  = 1'b1;
          sel_d   = LB_SEL;
          state_d = S_START;
        end else if (pick_found) begin
          pend_clr[pick_idx] = 1'b1;
          sel_d   = 4'(pick_idx);
          rr_d    = (pick_idx == PW'(NUM_BTN - 1)) ? '0 : pick_idx + PW'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (play_busy) begin
          state_d = S_PLAYING;
        end else if (cnt_q == TW'(START_TIMEOUT - 1)) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_PLAYING: begin
        if (!play_busy) begin
          state_d = S_IDLE;
        end else if ((lb_q && sel_q != LB_SEL) || retrig_hit) begin
          state_d  = S_ABORT;
          retrig_d = retrig_hit;
        end
      end
      S_ABORT: begin
        if (!play_busy) begin
          retrig_d = 1'b0;
          // a pending warning outranks the restart; the retriggered button is queued instead
          if (retrig_q && !lb_q) begin
            state_d = S_START;
          end else begin
            state_d    = S_IDLE;
            do_requeue = retrig_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    retrig_mask = '0;
    requeue     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      retrig_mask[i] = retrig_hit && (sel_q == 4'(i));
      requeue[i]     = do_requeue && (sel_q == 4'(i));
    end
    pend_d = (pend_q & ~pend_clr) | (btn_rise & ~retrig_mask) | requeue;
    lb_d   = (lb_q & ~lb_clr) | lb_rise;
  end

  assign play_start = (state_q == S_START);
  assign play_abort = (state_q == S_ABORT);
  assign play_sel   = sel_q;
  assign active     = (state_q != S_IDLE);
  assign start_fail = fail_q;

endmodule

`default_nettype wire

// File: doc/hk628_trigger_sched.md
# hk628_trigger_sched

Trigger scheduler between the joystick-derived button inputs and the single sample-playback engine inside the sound-toy core. It debounces eight sound buttons plus the low-battery button and turns each press into a request. It arbitrates pending requests round-robin onto the one playback engine through a start/busy handshake. The low-battery warning preempts any button sound.

## Interface
- NUM_BTN, 8, number of sound buttons; sound index i = button i.
- DEBOUNCE_CYCLES, 500000, clk cycles per debounce sample tick (10 ms at 50 MHz); must be ≥ 2.
- START_TIMEOUT, 16, cycles to wait for play_busy after play_start.

Ports:
- clk  in  1  core clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- btn  in  NUM_BTN  raw button levels, asynchronous, 1 = pressed.
- low_batt_btn  in  1  raw low-battery button level, asynchronous.
- play_busy  in  1  engine is playing a sound.
- play_start  out  1  one-cycle start pulse to the engine.
- play_abort  out  1  held high to stop the engine until play_busy falls.
- play_sel  out  4  sound index, valid while play_start is high; 0..NUM_BTN-1 = button, 8 = low-battery warning.
- active  out  1  scheduler is not in IDLE.
- start_fail  out  1  sticky; set on start timeout, cleared only by reset.

## Operation
- Input path: each of the 9 inputs passes through a 2-FF synchronizer.
- A shared prescaler produces a tick every DEBOUNCE_CYCLES cycles. On each tick, every synchronized input is sampled.
- The debounced state of an input updates only when two consecutive tick samples agree.
- A debounced 0→1 transition sets pending[i] (buttons) or lb_pending (low-battery). Setting an already-set bit has no effect: repeat presses coalesce.
- Debounced 1→0 transitions are ignored.
- FSM states: IDLE, START, WAIT_BUSY, PLAYING, ABORT.
- IDLE:
  - If lb_pending, clear it, set sel=8, go to START.
  - Otherwise, if pending≠0, pick the first set bit searching upward from rr_ptr with wrap, clear it, set sel to that index, set rr_ptr=(sel+1) mod NUM_BTN, go to START.
  - lb_pending always wins over pending.
- START: play_start=1 for exactly this cycle, play_sel=sel. Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - play_busy=1 → PLAYING.
  - If the counter reaches START_TIMEOUT, set start_fail and go to IDLE.
- PLAYING:
  - play_busy=0 → IDLE.
  - If lb_pending and sel≠8, go to ABORT; lb_pending stays set.
  - A sel=8 sound is never aborted.
- ABORT: play_abort=1 while in this state. play_busy=0 → IDLE, where lb_pending is served next.
- If a set and a clear of the same pending bit occur in the same cycle, the set wins.

## Timing
- Reset values:
  - play_start=0, play_abort=0, play_sel=0, active=0, start_fail=0.
  - pending=0, lb_pending=0, rr_ptr=0, state=IDLE, prescaler=0.
  - All debounced states, synchronizers and tick samples = 0.
- An input held during reset produces exactly one request after debounce.
- Press to debounced edge takes 2 sync cycles plus 2 to 3 ticks.
- Debounced edge in cycle N: pending is set at N+1, IDLE selects at N+1, and play_start is high in cycle N+2.
- After play_busy falls in PLAYING or ABORT, the next play_start comes 2 cycles later if a request is pending.
- Back-to-back play_start pulses are at least 4 cycles apart.
- Reset asserted mid-operation: play_start and play_abort are low from the next cycle and all requests are discarded. The engine is not signalled.

## Configuration
- HK628_SCHED_RETRIGGER_EN defined: in PLAYING, a debounced edge on the button whose index equals the current sel does not set pending. It forces ABORT, and when play_busy falls the same index restarts directly through START, bypassing rr_ptr.
- Undefined: that edge sets pending as normal and the sound replays after the current one ends.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Single press: btn[3] high for 40 cycles → exactly one play_start with play_sel=3. Hold play_busy for 10 cycles → active=0 afterwards.
- Simultaneous press: btn[1], btn[5] and btn[6] rise in the same cycle with rr_ptr=0 → play_start order 1, 5, 6, each after the previous play_busy falls.
- Bounce: btn[2] toggles every 2 cycles for 20 cycles, then settles high → exactly one play_start, play_sel=2.
- Preemption: during a sel=4 sound, press low_batt_btn → play_abort high until play_busy drops, then play_start with play_sel=8, then the pending queue resumes.
- Timeout: play_busy tied to 0 and btn[0] pressed → play_start then start_fail=1 after 16 cycles, FSM back in IDLE. Pulse reset for one cycle → start_fail=0 and all outputs at reset values.
- Retrigger: while playing sel=7, press btn[7] again. With HK628_SCHED_RETRIGGER_EN → ABORT then play_start with play_sel=7. Without it → replays after play_busy falls.
